// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store requesters onto one fixed-latency memory port.
// Define MEM_PORT_ARB_RR_EN for round-robin arbitration instead of data priority with a fetch starvation guard.
module mem_port_arbiter #(
  parameter int AW         = 16,
  parameter int DW         = 16,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_wen,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_req,
  output logic          mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic [3:0]    lat_q, lat_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          wen_q, wen_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          idle;
  logic          grant_i, grant_d;

  assign idle = (state_q == IDLE);

`ifdef MEM_PORT_ARB_RR_EN
  // rr_q = 0: fetch wins a tie; flips to the other requester after every grant.
  logic rr_q, rr_d;

  assign grant_i = idle & i_req & (~d_req | ~rr_q);
  assign grant_d = idle & d_req & (~i_req | rr_q);

  always_comb begin
    rr_d = rr_q;
    if (grant_i)      rr_d = 1'b1;
    else if (grant_d) rr_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_q <= 1'b0;
    else        rr_q <= rr_d;
  end
`else
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_q, starve_d;
  logic       starved;

  assign starved = (starve_q == STARVE_LIM);
  assign grant_i = idle & i_req & (~d_req | starved);
  assign grant_d = idle & d_req & ~(i_req & starved);

  always_comb begin
    starve_d = starve_q;
    if (grant_i)                 starve_d = '0;
    else if (grant_d && !i_req)  starve_d = '0;
    else if (grant_d && !starved) starve_d = starve_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_q <= '0;
    else        starve_q <= starve_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    lat_d   = lat_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_i || grant_d) begin
          owner_d = grant_d;
          addr_d  = grant_d ? d_addr : i_addr;
          wen_d   = grant_d & d_wen;
          wdata_d = grant_d ? d_wdata : '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        lat_d   = LAT_INIT;
        state_d = WAIT;
      end
      WAIT: begin
        if (lat_q == 4'd0) begin
          rdata_d = wen_q ? '0 : mem_rdata;
          state_d = RESP;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      lat_q   <= lat_d;
    end
  end

  // Transaction payload needs no reset: every output using it is gated by state.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wen_q   <= wen_d;
    wdata_q <= wdata_d;
    rdata_q <= rdata_d;
  end

  assign i_gnt     = grant_i;
  assign d_gnt     = grant_d;
  assign mem_req   = (state_q == ISSUE);
  assign mem_wen   = mem_req & wen_q;
  assign mem_addr  = mem_req ? addr_q : '0;
  assign mem_wdata = mem_wen ? wdata_q : '0;
  assign i_rvalid  = (state_q == RESP) & ~owner_q;
  assign d_rvalid  = (state_q == RESP) & owner_q;
  assign i_rdata   = i_rvalid ? rdata_q : '0;
  assign d_rdata   = d_rvalid ? rdata_q : '0;
  assign busy      = ~idle;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, fixed-latency memory between the instruction-fetch requester and the load/store requester of the 16-bit CPU.
- Sits between the CPU core and the memory.
- One transaction outstanding at a time.
- Fixed data priority with a starvation guard for fetch.

Parameters:
AW, 16, address width (byte address, passed through unmodified)
DW, 16, data width
MEM_LAT, 2, cycles from mem_req to valid mem_rdata (legal 1..15)
STARVE_MAX, 4, consecutive data grants allowed while fetch waits (legal 1..15)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
i_req  input  1  fetch request; held until i_gnt
i_addr  input  AW  fetch address
i_gnt  output  1  fetch accepted this cycle (combinational)
i_rvalid  output  1  one-cycle fetch response strobe
i_rdata  output  DW  fetch data, valid with i_rvalid
d_req  input  1  data request; held until d_gnt
d_wen  input  1  1 = store, 0 = load
d_addr  input  AW  data address
d_wdata  input  DW  store data
d_gnt  output  1  data request accepted this cycle (combinational)
d_rvalid  output  1  one-cycle data response strobe (loads and stores)
d_rdata  output  DW  load data; 0 for stores
mem_req  output  1  memory access strobe, exactly one cycle per transaction
mem_wen  output  1  write enable, qualified by mem_req
mem_addr  output  AW  memory address
mem_wdata  output  DW  memory write data
mem_rdata  input  DW  memory read data, valid MEM_LAT cycles after mem_req
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE.
  - All outputs 0; starvation counter 0; rr pointer = fetch.
  - In-flight transaction is dropped; no rvalid is ever issued for it.
  - Late mem_rdata is ignored.
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE: gnt is combinational from req and priority.
  - Handshake completes when req & gnt at the clock edge.
  - On handshake: latch requester id, addr, wen, wdata; go to ISSUE.
  - No requests: stay in IDLE.
- ISSUE (1 cycle): mem_req=1 with registered mem_addr, mem_wen, mem_wdata; load latency counter with MEM_LAT-1.
- WAIT: decrement counter; at 0, capture mem_rdata (forced to 0 if the transaction is a store); go to RESP.
  - With MEM_LAT=1, WAIT lasts 1 cycle and the capture happens in that cycle.
- RESP: assert rvalid of the owning requester for exactly 1 cycle with captured data; next state IDLE.
- Arbitration does not run in RESP. The next grant is at earliest the cycle after RESP.
- Timing: grant cycle G; mem_req at G+1; mem_rdata sampled at G+1+MEM_LAT; rvalid at G+2+MEM_LAT.
- Throughput: one transaction per MEM_LAT+3 cycles.
- gnt is never asserted outside IDLE. i_gnt and d_gnt are never both high.
- Priority, fixed mode: d_req wins over i_req, except when starve_cnt == STARVE_MAX, in which case fetch wins.
- Starvation counter:
  - Increments on a data grant while i_req=1 (saturates at STARVE_MAX).
  - Clears on any fetch grant.
  - Clears on a data grant with i_req=0.
- Outputs not owned by the current transaction stay 0. mem_wen=0 when mem_req=0.
- Requester inputs are sampled only at the handshake edge. Changes after grant have no effect.

Optional Feature:
- Macro: MEM_PORT_ARB_RR_EN.
- Defined: round-robin arbitration.
  - On simultaneous requests, grant the requester not granted last; a lone requester always wins.
  - rr pointer updates on every grant.
  - Starvation counter is removed and STARVE_MAX is unused.
- Undefined: fixed data priority with starvation guard as described above.

Test Plan:
- Reset then single fetch (i_req=1, i_addr=0x0010, mem holds 0x8123, MEM_LAT=2):
  - i_gnt at cycle 0; mem_req with mem_addr=0x0010 at cycle 1.
  - i_rvalid with i_rdata=0x8123 at cycle 4; busy high for cycles 1-4.
- Store (d_wen=1, d_addr=0x0200, d_wdata=0xBEEF):
  - One mem_req cycle with mem_wen=1, mem_wdata=0xBEEF.
  - d_rvalid with d_rdata=0x0000; i_rvalid stays 0.
- i_req and d_req held continuously, STARVE_MAX=4, fixed mode: grant sequence D,D,D,D,I,D,D,D,D,I.
  - No cycle with both gnts high.
- Same stimulus with MEM_PORT_ARB_RR_EN defined: grant sequence alternates I,D,I,D starting with fetch after reset.
- rst_n pulsed low during WAIT of a load:
  - All outputs go 0 immediately; no rvalid afterwards.
  - The next request after release is granted in IDLE normally.
- MEM_LAT=1, back-to-back fetches at 0x0000 and 0x0002:
  - Second i_gnt exactly 1 cycle after the first i_rvalid.
  - Second mem_req 4 cycles after the first.
